// File: rtl/alu_shift_if.sv
// alu_shift_if: the request/response bundle of the sequential shifter.
//   start      request strobe (sampled only while the shifter is idle)
//   A          operand, count shift amount 0-7, operation op code, C_in incoming carry
//   busy       operation in flight, done one-cycle completion strobe
//   result     shifted value, C/Z/S carry, zero and sign flags of result
// master drives the request side; slave is the shifter.
interface alu_shift_if;
   logic       start;
   logic [7:0] A;
   logic [2:0] count;
   logic [2:0] operation;
   logic       C_in;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       C;
   logic       Z;
   logic       S;

   modport master (
      output start, A, count, operation, C_in,
      input  busy, done, result, C, Z, S
   );

   modport slave (
      input  start, A, count, operation, C_in,
      output busy, done, result, C, Z, S
   );
endinterface

// File: rtl/alu_shift.sv
// alu_shift: multi-cycle 8-bit shifter/rotator, one bit position per clock.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset (0 = reset)
//   bus    alu_shift_if.slave: start/A/count/operation/C_in in,
//          busy/done/result/C/Z/S out
// Flow: IDLE accepts a request and captures operand, op, count and carry;
// SHIFT performs one step per cycle until the count is exhausted; DONE
// strobes done for one cycle while the registered result and flags hold
// until the next completion.
module alu_shift #(
   parameter logic [2:0] OP_SHL = 3'b000,
   parameter logic [2:0] OP_SHR = 3'b001,
   parameter logic [2:0] OP_SAL = 3'b010,
   parameter logic [2:0] OP_SAR = 3'b011,
   parameter logic [2:0] OP_ROL = 3'b100,
   parameter logic [2:0] OP_ROR = 3'b101,
   parameter logic [2:0] OP_RCL = 3'b110,
   parameter logic [2:0] OP_RCR = 3'b111
) (
   input  logic        clk,
   input  logic        reset,
   alu_shift_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] r_q, r_d;
   logic       c_q, c_d;
   logic [2:0] cnt_q, cnt_d;
   logic [2:0] op_q, op_d;
   logic [7:0] result_q, result_d;
   logic       cf_q, cf_d;
   logic       zf_q, zf_d;
   logic       sf_q, sf_d;

   // One bit step; returns {carry, value}.
   function automatic logic [8:0] shift_step(input logic [2:0] op,
                                             input logic [7:0] r,
                                             input logic       c);
      logic signed [7:0] r_s;
      logic [8:0]        res;
      r_s = r;
      res = {c, r};
      case (op)
         OP_SHL, OP_SAL: res = {r[7], r[6:0], 1'b0};
         OP_SHR:         res = {r[0], 1'b0, r[7:1]};
         OP_SAR:         res = {r[0], 8'(r_s >>> 1)};
         OP_ROL:         res = {r[7], r[6:0], r[7]};
         OP_ROR:         res = {r[0], r[0], r[7:1]};
         // Carry is the ninth bit of the rotation ring.
         OP_RCL:         res = {r, c};
         OP_RCR:         res = {r[0], c, r[7:1]};
         default:        res = {c, r};
      endcase
      return res;
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = (bus.count != 3'd0) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == 3'd1) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Working registers and result capture
   always_comb begin
      r_d      = r_q;
      c_d      = c_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      result_d = result_q;
      cf_d     = cf_q;
      zf_d     = zf_q;
      sf_d     = sf_q;
      if (state_q == ST_IDLE && bus.start) begin
         r_d   = bus.A;
         c_d   = bus.C_in;
         cnt_d = bus.count;
         op_d  = bus.operation;
      end else if (state_q == ST_SHIFT) begin
         {c_d, r_d} = shift_step(op_q, r_q, c_q);
         cnt_d      = cnt_q - 3'd1;
      end
      // Capture from the next working value so a zero count (straight from
      // IDLE) and the final shift step land in the outputs the same way.
      if (state_d == ST_DONE && state_q != ST_DONE) begin
         result_d = r_d;
         cf_d     = c_d;
         zf_d     = (r_d == 8'h00);
         sf_d     = r_d[7];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q      <= 8'h00;
         c_q      <= 1'b0;
         cnt_q    <= 3'd0;
         op_q     <= 3'd0;
         result_q <= 8'h00;
         cf_q     <= 1'b0;
         zf_q     <= 1'b0;
         sf_q     <= 1'b0;
      end else begin
         r_q      <= r_d;
         c_q      <= c_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         result_q <= result_d;
         cf_q     <= cf_d;
         zf_q     <= zf_d;
         sf_q     <= sf_d;
      end
   end

   // Outputs
   always_comb begin
      bus.busy   = (state_q != ST_IDLE);
      bus.done   = (state_q == ST_DONE);
      bus.result = result_q;
      bus.C      = cf_q;
      bus.Z      = zf_q;
      bus.S      = sf_q;
   end

endmodule

// File: tb/tb_alu_shift.sv
// tb_alu_shift: directed bench for alu_shift with hand-computed vectors.
module tb_alu_shift;

   localparam logic [2:0] SHL = 3'b000;
   localparam logic [2:0] SHR = 3'b001;
   localparam logic [2:0] SAL = 3'b010;
   localparam logic [2:0] SAR = 3'b011;
   localparam logic [2:0] ROL = 3'b100;
   localparam logic [2:0] ROR = 3'b101;
   localparam logic [2:0] RCL = 3'b110;
   localparam logic [2:0] RCR = 3'b111;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_shift_if bus ();

   alu_shift dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request, scramble the inputs after acceptance, then check
   // latency (cycles from presenting start to done), result, flags, and
   // that done drops after one cycle while the outputs hold.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [2:0] cnt, input logic cin,
                         input logic [7:0] exp_r, input logic exp_c);
      int n;
      bus.operation = op;
      bus.A         = a;
      bus.count     = cnt;
      bus.C_in      = cin;
      bus.start     = 1'b1;
      tick;
      bus.start     = 1'b0;
      bus.A         = ~a;
      bus.count     = ~cnt;
      bus.operation = ~op;
      bus.C_in      = ~cin;
      chk({tag, "_busy"}, 8'(bus.busy), 8'h01);
      n = 1;
      while (bus.done !== 1'b1 && n < 20) begin
         tick;
         n++;
      end
      chk({tag, "_latency"}, 8'(n), 8'(int'(cnt) + 1));
      chk({tag, "_result"}, bus.result, exp_r);
      chk({tag, "_C"}, 8'(bus.C), 8'(exp_c));
      chk({tag, "_Z"}, 8'(bus.Z), 8'(exp_r == 8'h00));
      chk({tag, "_S"}, 8'(bus.S), 8'(exp_r[7]));
      tick;
      chk({tag, "_done_drop"}, 8'(bus.done), 8'h00);
      chk({tag, "_idle"}, 8'(bus.busy), 8'h00);
      chk({tag, "_hold"}, bus.result, exp_r);
   endtask

   initial begin
      int seen;
      reset         = 1'b0;
      bus.start     = 1'b0;
      bus.A         = 8'h00;
      bus.count     = 3'd0;
      bus.operation = SHL;
      bus.C_in      = 1'b0;
      tick;
      tick;
      chk("rst_busy", 8'(bus.busy), 8'h00);
      chk("rst_done", 8'(bus.done), 8'h00);
      chk("rst_result", bus.result, 8'h00);
      chk("rst_flags", {5'd0, bus.C, bus.Z, bus.S}, 8'h00);
      reset = 1'b1;
      tick;

      run_op("shl81",   SHL, 8'h81, 3'd1, 1'b0, 8'h02, 1'b1);
      run_op("sar80",   SAR, 8'h80, 3'd3, 1'b0, 8'hF0, 1'b0);
      run_op("rcl80",   RCL, 8'h80, 3'd1, 1'b1, 8'h01, 1'b1);
      run_op("ror01",   ROR, 8'h01, 3'd7, 1'b0, 8'h02, 1'b0);
      run_op("shr00c0", SHR, 8'h00, 3'd0, 1'b1, 8'h00, 1'b1);
      run_op("shrB5",   SHR, 8'hB5, 3'd2, 1'b0, 8'h2D, 1'b0);
      run_op("rcr01",   RCR, 8'h01, 3'd1, 1'b0, 8'h00, 1'b1);
      run_op("salC0",   SAL, 8'hC0, 3'd2, 1'b0, 8'h00, 1'b1);
      run_op("rcl55",   RCL, 8'h55, 3'd7, 1'b0, 8'h95, 1'b0);
      run_op("rol96",   ROL, 8'h96, 3'd4, 1'b0, 8'h69, 1'b1);

      // Second start during SHIFT (and held into DONE) must be ignored.
      bus.operation = SAR;
      bus.A         = 8'h80;
      bus.count     = 3'd3;
      bus.C_in      = 1'b0;
      bus.start     = 1'b1;
      tick;
      bus.operation = SHL;
      bus.A         = 8'hFF;
      bus.count     = 3'd1;
      tick;
      tick;
      tick;
      chk("ign_done", 8'(bus.done), 8'h01);
      chk("ign_result", bus.result, 8'hF0);
      chk("ign_S", 8'(bus.S), 8'h01);
      tick;
      bus.start = 1'b0;
      chk("ign_idle", 8'(bus.busy), 8'h00);
      chk("ign_hold", bus.result, 8'hF0);
      tick;

      // Reset in the middle of a shift aborts without a done strobe.
      bus.operation = SHL;
      bus.A         = 8'hFF;
      bus.count     = 3'd5;
      bus.C_in      = 1'b1;
      bus.start     = 1'b1;
      tick;
      bus.start = 1'b0;
      tick;
      tick;
      reset     = 1'b0;
      bus.start = 1'b1;
      tick;
      chk("abort_busy", 8'(bus.busy), 8'h00);
      chk("abort_done", 8'(bus.done), 8'h00);
      chk("abort_result", bus.result, 8'h00);
      chk("abort_flags", {5'd0, bus.C, bus.Z, bus.S}, 8'h00);
      bus.start = 1'b0;
      reset     = 1'b1;
      seen      = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (bus.done === 1'b1) seen++;
      end
      chk("abort_no_done", 8'(seen), 8'h00);

      // Start held high: ROL 01 by 1 completes every third cycle.
      bus.operation = ROL;
      bus.A         = 8'h01;
      bus.count     = 3'd1;
      bus.C_in      = 1'b0;
      bus.start     = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick;
         chk($sformatf("b2b_done%0d", i), 8'(bus.done), 8'((i % 3) == 2));
         if ((i % 3) == 2) begin
            chk($sformatf("b2b_result%0d", i), bus.result, 8'h02);
            chk($sformatf("b2b_C%0d", i), 8'(bus.C), 8'h00);
         end
      end
      bus.start = 1'b0;
      tick;
      tick;
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
